// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// hex font, the all-off pattern, page clamping and counter sizing.
package seg_pkg;

    // All segments dark, in active-low {g,f,e,d,c,b,a} form.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex font 0..F, active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Out-of-range manual selections show the last page instead of garbage.
    function automatic int unsigned clamp_page(input int unsigned sel,
                                               input int unsigned pages);
        return (sel >= pages) ? (pages - 1) : sel;
    endfunction

    // Counter width for a bound; never narrower than one bit.
    function automatic int unsigned min_width(input int unsigned bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Bus between the debug-word source and the scan driver: display data and
// controls towards the driver, strobes/segments and status back out.
interface seg_scan_display_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int PAGES  = 2
);
    localparam int PW = min_width(PAGES);

    logic [4*DIGITS*PAGES-1:0] data;
    logic [PW-1:0]             page_sel;
    logic                      auto_page;
    logic                      lz_blank;
    logic [DIGITS-1:0]         dp_in;
    logic                      enable;

    logic [DIGITS-1:0]         bit_sel;
    logic [6:0]                seg_sel;
    logic                      dp_out;
    logic [PW-1:0]             page_cur;
    logic                      frame_tick;

    // Source side: drives data and controls, watches the display outputs.
    modport master (
        output data, page_sel, auto_page, lz_blank, dp_in, enable,
        input  bit_sel, seg_sel, dp_out, page_cur, frame_tick
    );

    // Driver side.
    modport slave (
        input  data, page_sel, auto_page, lz_blank, dp_in, enable,
        output bit_sel, seg_sel, dp_out, page_cur, frame_tick
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder. Output is always active-low;
// the caller handles polarity at its output registers.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Blanked digits go fully dark, otherwise look up the hex glyph.
    always_comb begin
        o_seg = SEG_FONT[i_nibble];
        if (i_blank) begin
            o_seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver. A prescaler paces the digit scan;
// each frame start snapshots one page of the debug word so the whole frame
// is drawn from coherent data. Pages are chosen manually or cycled after a
// dwell count, with leading-zero blanking, decimal points, a live blank
// enable and selectable output polarity.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PAGES      = 2,
    parameter int SCAN_DIV   = 100000,
    parameter int AUTO_DWELL = 500,
    parameter int ACTIVE_LOW = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_display_if.slave bus
);

    localparam int PW = min_width(PAGES);
    localparam int DW = min_width(DIGITS);
    localparam int CW = min_width(SCAN_DIV);
    localparam int FW = min_width(AUTO_DWELL);

    // Internal patterns are active-low; this flips them once at the outputs.
    localparam logic INVERT = (ACTIVE_LOW == 0);

    logic [CW-1:0]         r_pc;
    logic [DW-1:0]         r_di;
    logic [FW-1:0]         r_fc;
    logic [PW-1:0]         r_page_cur;
    logic                  r_frame_evt;
    logic                  r_valid;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [DIGITS-1:0]     r_dp_shadow;
    logic                  r_lz_shadow;
    logic [DIGITS-1:0]     r_bit_sel;
    logic [6:0]            r_seg_sel;
    logic                  r_dp_out;
    logic                  r_frame_tick;

    logic                  w_tick;
    logic                  w_frame_start;
    logic [PW-1:0]         w_page_next;
    logic [FW-1:0]         w_fc_next;
    logic [4*DIGITS-1:0]   w_snap;
    logic [DIGITS-1:0]     w_zero;
    logic [DIGITS-1:0]     w_blank_mask;
    logic [3:0]            w_cur_nib;
    logic [6:0]            w_dec_seg;
    logic [DIGITS-1:0]     w_strobe_low;
    logic [DIGITS-1:0]     w_bit_low;
    logic [6:0]            w_seg_low;
    logic                  w_dp_low;

    assign w_tick        = (r_pc == CW'(SCAN_DIV - 1));
    assign w_frame_start = w_tick && (r_di == DW'(DIGITS - 1));

    // Prescaler and digit index; also marks the frame-start edge and whether
    // a real frame has been captured since reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_di        <= DW'(DIGITS - 1);
            r_frame_evt <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_pc        <= w_tick ? '0 : r_pc + CW'(1);
            if (w_tick) begin
                r_di <= (r_di == DW'(DIGITS - 1)) ? '0 : r_di + DW'(1);
            end
            r_frame_evt <= w_frame_start;
            if (w_frame_start) begin
                r_valid <= 1'b1;
            end
        end
    end

    // Page chosen for the coming frame: dwell-based rotation in auto mode,
    // clamped manual selection otherwise.
    always_comb begin
        w_page_next = r_page_cur;
        w_fc_next   = r_fc;
        if (bus.auto_page) begin
            if (r_fc == FW'(AUTO_DWELL - 1)) begin
                w_fc_next   = '0;
                w_page_next = (r_page_cur == PW'(PAGES - 1)) ? '0
                                                             : r_page_cur + PW'(1);
            end else begin
                w_fc_next = r_fc + FW'(1);
            end
        end else begin
            w_fc_next   = '0;
            w_page_next = PW'(clamp_page(32'(bus.page_sel), PAGES));
        end
    end

    // Page register moves only at frame starts; the dwell counter is parked
    // at zero whenever auto mode is off so rotation restarts cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_page_cur <= '0;
            r_fc       <= '0;
        end else begin
            if (w_frame_start) begin
                r_page_cur <= w_page_next;
            end
            if (!bus.auto_page) begin
                r_fc <= '0;
            end else if (w_frame_start) begin
                r_fc <= w_fc_next;
            end
        end
    end

    // Per-digit slice of the incoming page and its zero flag.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_snap[4*gi +: 4] = bus.data[4*(int'(w_page_next)*DIGITS + gi) +: 4];
        assign w_zero[gi]        = (r_shadow[4*gi +: 4] == 4'h0);
    end

    // Frame-coherent snapshot; contents only matter once r_valid is set.
    always_ff @(posedge clk) begin
        if (w_frame_start) begin
            r_shadow    <= w_snap;
            r_dp_shadow <= bus.dp_in;
            r_lz_shadow <= bus.lz_blank;
        end
    end

    // A digit is blanked when it and every digit to its left are zero;
    // digit 0 always shows so a zero value still reads as "0".
    always_comb begin
        logic v_run;
        v_run        = 1'b1;
        w_blank_mask = '0;
        for (int d = DIGITS - 1; d > 0; d--) begin
            v_run           = v_run & w_zero[d];
            w_blank_mask[d] = r_lz_shadow & v_run;
        end
    end

    assign w_cur_nib    = r_shadow[4*int'(r_di) +: 4];
    assign w_strobe_low = ~(DIGITS'(1) << r_di);

    seg_hex_decode u_decode (
        .i_nibble (w_cur_nib),
        .i_blank  (w_blank_mask[r_di]),
        .o_seg    (w_dec_seg)
    );

    // Active-low view of the outputs; dark when disabled or before the
    // first captured frame.
    always_comb begin
        w_bit_low = '1;
        w_seg_low = SEG_OFF;
        w_dp_low  = 1'b1;
        if (bus.enable && r_valid) begin
            w_bit_low = w_strobe_low;
            w_seg_low = w_dec_seg;
            w_dp_low  = ~r_dp_shadow[r_di];
        end
    end

    // Output registers with polarity applied; frame_tick trails the
    // frame-start edge so it lines up with the first digit's strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_sel    <= {DIGITS{1'b1}} ^ {DIGITS{INVERT}};
            r_seg_sel    <= SEG_OFF ^ {7{INVERT}};
            r_dp_out     <= 1'b1 ^ INVERT;
            r_frame_tick <= 1'b0;
        end else begin
            r_bit_sel    <= w_bit_low ^ {DIGITS{INVERT}};
            r_seg_sel    <= w_seg_low ^ {7{INVERT}};
            r_dp_out     <= w_dp_low ^ INVERT;
            r_frame_tick <= r_frame_evt;
        end
    end

    assign bus.bit_sel    = r_bit_sel;
    assign bus.seg_sel    = r_seg_sel;
    assign bus.dp_out     = r_dp_out;
    assign bus.page_cur   = r_page_cur;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: an active-low 4x2 build driven from a vector
// table, an active-high twin sharing its inputs, and a 1-digit 3-page build
// for the single-cycle-frame and page-clamp corners.
module tb_seg_scan_display;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_display_if #(.DIGITS(4), .PAGES(2)) bus_a ();
    seg_scan_display_if #(.DIGITS(4), .PAGES(2)) bus_b ();
    seg_scan_display_if #(.DIGITS(1), .PAGES(3)) bus_c ();

    seg_scan_display #(.DIGITS(4), .PAGES(2), .SCAN_DIV(4), .AUTO_DWELL(2), .ACTIVE_LOW(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    seg_scan_display #(.DIGITS(4), .PAGES(2), .SCAN_DIV(4), .AUTO_DWELL(2), .ACTIVE_LOW(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    seg_scan_display #(.DIGITS(1), .PAGES(3), .SCAN_DIV(1), .AUTO_DWELL(1), .ACTIVE_LOW(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    assign bus_b.data      = bus_a.data;
    assign bus_b.page_sel  = bus_a.page_sel;
    assign bus_b.auto_page = bus_a.auto_page;
    assign bus_b.lz_blank  = bus_a.lz_blank;
    assign bus_b.dp_in     = bus_a.dp_in;
    assign bus_b.enable    = bus_a.enable;

    typedef struct {
        logic [31:0] data;
        logic        ps;
        logic        lz;
        logic [3:0]  dp;
        logic [27:0] segs;     // expected seg_sel per digit, {d3,d2,d1,d0}
        logic [3:0]  dpx;      // expected dp_out per digit
        logic        page;
        logic [31:0] mid_data; // applied at digit 2 of the checked frame
        logic        mid_ps;
        logic        mid_en;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ft(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus_a.frame_tick !== 1'b1 && n < 40);
        if (bus_a.frame_tick !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_tick_timeout: no pulse within %0d cycles, one required", n);
        end
    endtask

    task automatic apply(input vec_t v);
        bus_a.data     = v.data;
        bus_a.page_sel = v.ps;
        bus_a.lz_blank = v.lz;
        bus_a.dp_in    = v.dp;
        bus_a.enable   = 1'b1;
    endtask

    initial begin
        int          n;
        int          j;
        logic [3:0]  one;
        logic [3:0]  e_bit;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [31:0] pg_exp [4];
        logic [31:0] sg_exp [4];

        one = 4'b0001;
        vecs[0] = '{32'h89AB_1234, 1'b0, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 1'b0, 32'h89AB_FFFF, 1'b1, 1'b1};
        vecs[1] = '{32'h89AB_1234, 1'b1, 1'b0, 4'b0000, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1111, 1'b1, 32'h89AB_1234, 1'b1, 1'b1};
        vecs[2] = '{32'h89AB_0005, 1'b0, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111, 1'b0, 32'h89AB_0005, 1'b0, 1'b1};
        vecs[3] = '{32'h89AB_0000, 1'b0, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 1'b0, 32'h89AB_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h89AB_0105, 1'b0, 1'b1, 4'b0000, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111, 1'b0, 32'h89AB_0105, 1'b0, 1'b1};
        vecs[5] = '{32'h89AB_CDEF, 1'b0, 1'b0, 4'b0001, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1110, 1'b0, 32'h89AB_CDEF, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0000, 1'b0, 1'b1, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 1'b0, 32'h0000_0000, 1'b0, 1'b1};

        rst_n           = 1'b0;
        bus_a.auto_page = 1'b0;
        apply(vecs[0]);
        bus_c.data      = 12'hCBA;
        bus_c.page_sel  = 2'd3;
        bus_c.auto_page = 1'b0;
        bus_c.lz_blank  = 1'b0;
        bus_c.dp_in     = 1'b0;
        bus_c.enable    = 1'b1;
        repeat (3) step();

        // Reset state, both polarities.
        chk("rst_bit_sel", 32'(bus_a.bit_sel), 32'hF);
        chk("rst_seg_sel", 32'(bus_a.seg_sel), 32'h7F);
        chk("rst_dp_out", 32'(bus_a.dp_out), 32'h1);
        chk("rst_page_cur", 32'(bus_a.page_cur), 32'h0);
        chk("rst_frame_tick", 32'(bus_a.frame_tick), 32'h0);
        chk("rst_hi_bit_sel", 32'(bus_b.bit_sel), 32'h0);
        chk("rst_hi_seg_sel", 32'(bus_b.seg_sel), 32'h0);
        chk("rst_hi_dp_out", 32'(bus_b.dp_out), 32'h0);

        // First frame after release.
        rst_n = 1'b1;
        wait_ft(n);
        $display("first frame_tick after %0d cycles", n);
        chk("first_tick_latency", 32'(n), 32'd5);
        chk("first_bit_sel", 32'(bus_a.bit_sel), 32'hE);
        chk("first_seg_sel", 32'(bus_a.seg_sel), 32'h19);
        chk("first_hi_bit_sel", 32'(bus_b.bit_sel), 32'h1);
        chk("first_hi_seg_sel", 32'(bus_b.seg_sel), 32'h66);
        chk("first_hi_dp_out", 32'(bus_b.dp_out), 32'h0);

        // Table: one frame per vector, 15 cycles of the frame checked.
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            wait_ft(n);
            if (i > 0) chk("frame_gap", 32'(n), 32'd2);
            for (int k = 0; k < 15; k++) begin
                if (k > 0) step();
                j     = k / 4;
                e_bit = ~(one << j);
                e_seg = vecs[i].segs[7*j +: 7];
                e_dp  = vecs[i].dpx[j];
                if (!vecs[i].mid_en && k > 8) begin
                    e_bit = 4'hF;
                    e_seg = 7'h7F;
                    e_dp  = 1'b1;
                end
                chk("vec_bit_sel", 32'(bus_a.bit_sel), 32'(e_bit));
                chk("vec_seg_sel", 32'(bus_a.seg_sel), 32'(e_seg));
                chk("vec_dp_out", 32'(bus_a.dp_out), 32'(e_dp));
                chk("vec_frame_tick", 32'(bus_a.frame_tick), (k == 0) ? 32'h1 : 32'h0);
                chk("vec_page_cur", 32'(bus_a.page_cur), 32'(vecs[i].page));
                if (k == 8) begin
                    bus_a.data     = vecs[i].mid_data;
                    bus_a.page_sel = vecs[i].mid_ps;
                    bus_a.enable   = vecs[i].mid_en;
                end
            end
            $display("vector %0d: data=%h page_sel=%0d lz=%0d dp=%b checked", i,
                     vecs[i].data, vecs[i].ps, vecs[i].lz, vecs[i].dp);
        end

        // Auto page cycling with a dwell of two frames.
        apply(vecs[0]);
        wait_ft(n);
        chk("auto_gap0", 32'(n), 32'd2);
        chk("auto_page0", 32'(bus_a.page_cur), 32'h0);
        bus_a.auto_page = 1'b1;
        pg_exp = '{32'h0, 32'h1, 32'h1, 32'h0};
        sg_exp = '{32'h19, 32'h03, 32'h03, 32'h19};
        for (int f = 0; f < 4; f++) begin
            wait_ft(n);
            chk("auto_gap", 32'(n), 32'd16);
            chk("auto_page_cur", 32'(bus_a.page_cur), pg_exp[f]);
            chk("auto_seg_sel", 32'(bus_a.seg_sel), sg_exp[f]);
            $display("auto frame %0d: page_cur=%0d seg_sel=%h", f, bus_a.page_cur, bus_a.seg_sel);
        end

        // Reset in the middle of a page-1 frame.
        bus_a.auto_page = 1'b0;
        bus_a.page_sel  = 1'b1;
        wait_ft(n);
        chk("pre_rst_page_cur", 32'(bus_a.page_cur), 32'h1);
        repeat (5) step();
        rst_n          = 1'b0;
        bus_a.page_sel = 1'b0;
        step();
        chk("midrst_bit_sel", 32'(bus_a.bit_sel), 32'hF);
        chk("midrst_seg_sel", 32'(bus_a.seg_sel), 32'h7F);
        chk("midrst_dp_out", 32'(bus_a.dp_out), 32'h1);
        chk("midrst_page_cur", 32'(bus_a.page_cur), 32'h0);
        chk("midrst_frame_tick", 32'(bus_a.frame_tick), 32'h0);
        rst_n = 1'b1;
        wait_ft(n);
        chk("midrst_latency", 32'(n), 32'd5);
        chk("midrst_first_bit_sel", 32'(bus_a.bit_sel), 32'hE);
        chk("midrst_first_seg_sel", 32'(bus_a.seg_sel), 32'h19);
        $display("mid-frame reset: restart after %0d cycles", n);

        // Single-digit, three-page, one-cycle-frame build.
        chk("c_page_clamp", 32'(bus_c.page_cur), 32'h2);
        chk("c_seg_sel", 32'(bus_c.seg_sel), 32'h46);
        chk("c_bit_sel", 32'(bus_c.bit_sel), 32'h0);
        chk("c_frame_tick", 32'(bus_c.frame_tick), 32'h1);
        bus_c.auto_page = 1'b1;
        step();
        chk("c_auto_page1", 32'(bus_c.page_cur), 32'h0);
        chk("c_auto_seg1", 32'(bus_c.seg_sel), 32'h46);
        step();
        chk("c_auto_page2", 32'(bus_c.page_cur), 32'h1);
        chk("c_auto_seg2", 32'(bus_c.seg_sel), 32'h08);
        step();
        chk("c_auto_page3", 32'(bus_c.page_cur), 32'h2);
        chk("c_auto_seg3", 32'(bus_c.seg_sel), 32'h03);
        $display("single-digit build: page wrap 2->0->1->2 checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
